// File: rtl/ref_particle_prefetcher.sv
// Reference particle prefetcher: captures in-order references from the home-cell broadcast into a small FIFO.
// Optional miss statistics enabled by defining REF_PREFETCH_STATS_EN.
module ref_particle_prefetcher #(
  parameter int OFFSET_WIDTH = 29,
  parameter int CELL_ID_WIDTH = 3,
  parameter logic [CELL_ID_WIDTH-1:0] CELL_ID = 3'b010,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int PREFETCH_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_is_count,
  input  logic [PARTICLE_ID_WIDTH-1:0] in_id,
  input  logic [OFFSET_WIDTH-1:0] in_x,
  input  logic [OFFSET_WIDTH-1:0] in_y,
  input  logic [OFFSET_WIDTH-1:0] in_z,
  input  logic ref_advance,
  output logic ref_valid,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic [CELL_ID_WIDTH+OFFSET_WIDTH-1:0] ref_x,
  output logic [CELL_ID_WIDTH+OFFSET_WIDTH-1:0] ref_y,
  output logic [CELL_ID_WIDTH+OFFSET_WIDTH-1:0] ref_z,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_particle_num,
  output logic frame_done,
  output logic [15:0] missed_captures
);

  localparam int DATA_WIDTH = CELL_ID_WIDTH + OFFSET_WIDTH;
  localparam int PW = PARTICLE_ID_WIDTH;
  localparam int AW = $clog2(PREFETCH_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(PREFETCH_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0] num_q;
  logic [PW:0] cap_id_q;
  logic [PW:0] pop_cnt_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] cnt_q, cnt_d;

  logic [PW-1:0] id_mem_q [PREFETCH_DEPTH];
  logic [DATA_WIDTH-1:0] x_mem_q [PREFETCH_DEPTH];
  logic [DATA_WIDTH-1:0] y_mem_q [PREFETCH_DEPTH];
  logic [DATA_WIDTH-1:0] z_mem_q [PREFETCH_DEPTH];

  logic hdr, pop, push, cap_ok, full;
  logic [PW-1:0] hdr_cnt;
  logic [PW:0] num_ext;

  assign hdr = in_valid & in_is_count;
  assign hdr_cnt = in_x[PW-1:0];
  assign num_ext = {1'b0, num_q};
  assign full = (cnt_q == FULL_CNT);
  assign ref_valid = (cnt_q != '0);

  // Header wins over a same-cycle advance
  assign pop = ref_advance & ref_valid & ~hdr;

  assign cap_ok = (state_q == S_RUN) & in_valid & ~in_is_count
                & (in_id == cap_id_q[PW-1:0])
                & (cap_id_q < num_ext);

  assign push = cap_ok & (~full | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push & ~pop)
      cnt_d = cnt_q + 1'b1;
    else if (pop & ~push)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (hdr)
      state_d = (hdr_cnt == '0) ? S_DONE : S_RUN;
    else if (pop && ((pop_cnt_q + 1'b1) == num_ext))
      state_d = S_DONE;
  end

  always_comb begin
    frame_done = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q <= '0;
      cap_id_q <= '0;
      pop_cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < PREFETCH_DEPTH; i++) begin
        id_mem_q[i] <= '0;
        x_mem_q[i] <= '0;
        y_mem_q[i] <= '0;
        z_mem_q[i] <= '0;
      end
    end else if (hdr) begin
      num_q <= hdr_cnt;
      cap_id_q <= '0;
      pop_cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        id_mem_q[wr_ptr_q] <= in_id;
        x_mem_q[wr_ptr_q] <= {CELL_ID, in_x};
        y_mem_q[wr_ptr_q] <= {CELL_ID, in_y};
        z_mem_q[wr_ptr_q] <= {CELL_ID, in_z};
        wr_ptr_q <= wr_ptr_q + 1'b1;
        cap_id_q <= cap_id_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        pop_cnt_q <= pop_cnt_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

  assign ref_id = id_mem_q[rd_ptr_q];
  assign ref_x = x_mem_q[rd_ptr_q];
  assign ref_y = y_mem_q[rd_ptr_q];
  assign ref_z = z_mem_q[rd_ptr_q];
  assign ref_particle_num = num_q;

`ifdef REF_PREFETCH_STATS_EN
  logic miss;
  logic [15:0] miss_q;

  // Matching beat lost to a full FIFO; the broadcaster must re-send it
  assign miss = cap_ok & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      miss_q <= '0;
    else if (hdr)
      miss_q <= '0;
    else if (miss && (miss_q != 16'hFFFF))
      miss_q <= miss_q + 1'b1;
  end

  assign missed_captures = miss_q;
`else
  assign missed_captures = '0;
`endif

endmodule

// File: tb/tb_ref_particle_prefetcher.sv
// Directed self-checking bench for ref_particle_prefetcher.
// Expected miss counts follow REF_PREFETCH_STATS_EN.
module tb_ref_particle_prefetcher;

`ifdef REF_PREFETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_is_count, ref_advance;
  logic [6:0] in_id;
  logic [28:0] in_x, in_y, in_z;
  logic ref_valid, frame_done;
  logic [6:0] ref_id, ref_particle_num;
  logic [31:0] ref_x, ref_y, ref_z;
  logic [15:0] missed_captures;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ref_particle_prefetcher dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_is_count(in_is_count),
    .in_id(in_id),
    .in_x(in_x),
    .in_y(in_y),
    .in_z(in_z),
    .ref_advance(ref_advance),
    .ref_valid(ref_valid),
    .ref_id(ref_id),
    .ref_x(ref_x),
    .ref_y(ref_y),
    .ref_z(ref_z),
    .ref_particle_num(ref_particle_num),
    .frame_done(frame_done),
    .missed_captures(missed_captures)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rx(input logic [28:0] x);
    return {3'b010, x};
  endfunction

  function automatic logic [31:0] miss_exp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic beat(input logic v, input logic c, input logic [6:0] id,
                      input logic [28:0] x, input logic adv);
    in_valid = v;
    in_is_count = c;
    in_id = id;
    in_x = x;
    in_y = x + 29'd100;
    in_z = x + 29'd200;
    ref_advance = adv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_is_count = 1'b0;
    ref_advance = 1'b0;
  endtask

  task automatic hdr(input logic [6:0] n, input logic adv);
    beat(1'b1, 1'b1, 7'd0, {22'd0, n}, adv);
  endtask

  task automatic dat(input logic [6:0] id, input logic [28:0] x);
    beat(1'b1, 1'b0, id, x, 1'b0);
  endtask

  task automatic pop1();
    beat(1'b0, 1'b0, 7'd0, 29'd0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_is_count = 1'b0;
    in_id = '0;
    in_x = '0;
    in_y = '0;
    in_z = '0;
    ref_advance = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ref_valid), 32'd0);
    chk("rst_id", 32'(ref_id), 32'd0);
    chk("rst_x", ref_x, 32'd0);
    chk("rst_num", 32'(ref_particle_num), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_miss", 32'(missed_captures), 32'd0);
    rst = 1'b0;

    // basic count=3 frame
    hdr(7'd3, 1'b0);
    chk("h3_valid", 32'(ref_valid), 32'd0);
    chk("h3_done", 32'(frame_done), 32'd0);
    chk("h3_num", 32'(ref_particle_num), 32'd3);
    dat(7'd0, 29'd5);
    chk("c0_valid", 32'(ref_valid), 32'd1);
    chk("c0_id", 32'(ref_id), 32'd0);
    chk("c0_x", ref_x, 32'h4000_0005);
    chk("c0_z", ref_z, rx(29'd205));
    dat(7'd1, 29'd6);
    dat(7'd2, 29'd7);
    chk("c2_head", 32'(ref_id), 32'd0);
    pop1();
    chk("p1_id", 32'(ref_id), 32'd1);
    chk("p1_x", ref_x, rx(29'd6));
    pop1();
    chk("p2_id", 32'(ref_id), 32'd2);
    chk("p2_y", ref_y, rx(29'd107));
    chk("p2_done", 32'(frame_done), 32'd0);
    pop1();
    chk("p3_valid", 32'(ref_valid), 32'd0);
    chk("p3_done", 32'(frame_done), 32'd1);

    // overflow and re-broadcast, depth 4, count 8
    hdr(7'd8, 1'b0);
    chk("h8_done", 32'(frame_done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      dat(7'(i), 29'(10 + i));
      if (i == 4)
        chk("ov_miss4", 32'(missed_captures), miss_exp(1));
    end
    chk("ov_head", 32'(ref_id), 32'd0);
    chk("ov_miss", 32'(missed_captures), miss_exp(1));
    pop1();
    pop1();
    chk("ov_pop2", 32'(ref_id), 32'd2);
    for (int i = 4; i < 8; i++)
      dat(7'(i), 29'(20 + i));
    chk("rb_miss", 32'(missed_captures), miss_exp(2));
    pop1();
    chk("rb_h3", 32'(ref_id), 32'd3);
    pop1();
    chk("rb_h4", 32'(ref_id), 32'd4);
    chk("rb_x4", ref_x, rx(29'd24));
    pop1();
    chk("rb_h5", 32'(ref_id), 32'd5);
    pop1();
    chk("rb_empty", 32'(ref_valid), 32'd0);
    chk("rb_done", 32'(frame_done), 32'd0);

    // out-of-order beats
    hdr(7'd2, 1'b0);
    chk("oo_miss_clr", 32'(missed_captures), 32'd0);
    dat(7'd1, 29'd31);
    chk("oo_skip", 32'(ref_valid), 32'd0);
    dat(7'd0, 29'd30);
    chk("oo_id0", 32'(ref_id), 32'd0);
    dat(7'd1, 29'd31);
    pop1();
    chk("oo_id1", 32'(ref_id), 32'd1);
    chk("oo_x1", ref_x, rx(29'd31));
    pop1();
    chk("oo_done", 32'(frame_done), 32'd1);

    // zero count
    hdr(7'd0, 1'b0);
    chk("z_done", 32'(frame_done), 32'd1);
    chk("z_valid", 32'(ref_valid), 32'd0);
    dat(7'd0, 29'd1);
    chk("z_ign", 32'(ref_valid), 32'd0);

    // full FIFO with same-cycle pop and push
    hdr(7'd6, 1'b0);
    for (int i = 0; i < 4; i++)
      dat(7'(i), 29'(40 + i));
    beat(1'b1, 1'b0, 7'd4, 29'd44, 1'b1);
    chk("pp_head", 32'(ref_id), 32'd1);
    dat(7'd5, 29'd45);
    chk("pp_miss", 32'(missed_captures), miss_exp(1));
    pop1();
    pop1();
    pop1();
    chk("pp_h4", 32'(ref_id), 32'd4);
    chk("pp_x4", ref_x, rx(29'd44));
    pop1();
    chk("pp_empty", 32'(ref_valid), 32'd0);
    chk("pp_done", 32'(frame_done), 32'd0);

    // header mid-frame, with a competing advance
    hdr(7'd3, 1'b0);
    dat(7'd0, 29'd50);
    dat(7'd1, 29'd51);
    hdr(7'd2, 1'b1);
    chk("mh_valid", 32'(ref_valid), 32'd0);
    chk("mh_num", 32'(ref_particle_num), 32'd2);
    dat(7'd0, 29'd60);
    chk("mh_id", 32'(ref_id), 32'd0);
    chk("mh_x", ref_x, rx(29'd60));

    // async reset mid-frame
    dat(7'd1, 29'd61);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(ref_valid), 32'd0);
    chk("ar_id", 32'(ref_id), 32'd0);
    chk("ar_x", ref_x, 32'd0);
    chk("ar_num", 32'(ref_particle_num), 32'd0);
    chk("ar_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    dat(7'd0, 29'd70);
    chk("ar_idle", 32'(ref_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ref_particle_prefetcher.md
# ref_particle_prefetcher

Parametrised successor to the single-register reference extractor in the force-pipeline front end. Watches the home-cell particle broadcast stream, captures the particle count header, then captures reference particles in ascending ID order into a small prefetch FIFO. The current reference (the FIFO head, tagged with the home cell ID) is presented to the force evaluator until the evaluator pops it with `ref_advance`. A frame-complete flag is raised once every reference has been consumed.

## Interface
Parameters:
- `OFFSET_WIDTH`, 29, per-axis position offset width
- `CELL_ID_WIDTH`, 3, cell ID field width; `DATA_WIDTH` = `CELL_ID_WIDTH + OFFSET_WIDTH` (derived localparam)
- `CELL_ID`, 3'b010, cell ID prepended to every captured offset
- `PARTICLE_ID_WIDTH`, 7, particle ID and count width
- `PREFETCH_DEPTH`, 4, FIFO entries; power of two, ≥2

Ports:
- `clk` in 1: sole clock
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: broadcast beat valid
- `in_is_count` in 1: beat is a count header; count is in `in_x[PARTICLE_ID_WIDTH-1:0]`
- `in_id` in `PARTICLE_ID_WIDTH`: particle ID of the beat
- `in_x`, `in_y`, `in_z` in `OFFSET_WIDTH` each: raw offsets
- `ref_advance` in 1: evaluator has finished the current reference; pop it
- `ref_valid` out 1: `ref_*` outputs hold a valid reference
- `ref_id` out `PARTICLE_ID_WIDTH`: ID of the current reference
- `ref_x`, `ref_y`, `ref_z` out `DATA_WIDTH` each: `{CELL_ID, offset}`
- `ref_particle_num` out `PARTICLE_ID_WIDTH`: latched count
- `frame_done` out 1: all references consumed
- `missed_captures` out 16: stats counter (see Configuration)

## Operation
- States:
  - IDLE: awaiting a header.
  - RUN: capturing and serving references.
  - DONE: frame complete.
- Header beat (`in_valid & in_is_count`), accepted in any state:
  - latch `ref_particle_num`, flush the FIFO, clear `cap_id` and `pop_cnt`.
  - go to RUN; if the count is 0, go to DONE instead.
  - a header takes priority over any same-cycle `ref_advance`.
- Capture in RUN: a data beat with `in_id == cap_id`, `cap_id < ref_particle_num` and the FIFO not full pushes `{in_id, CELL_ID|x, CELL_ID|y, CELL_ID|z}` and increments `cap_id`.
  - A full FIFO with a same-cycle pop counts as not full.
  - All other data beats are ignored.
  - Data beats in IDLE or DONE are ignored.
- Pop: `ref_advance & ref_valid` pops the head and increments `pop_cnt`.
  - `ref_advance` while `ref_valid`=0 is ignored.
  - When `pop_cnt` reaches `ref_particle_num`, go to DONE.
- `ref_*` outputs are the registered FIFO head. `ref_valid` = FIFO not empty. `frame_done` = (state == DONE).
- A matching beat dropped because the FIFO is full is not retried; the broadcaster re-broadcasts the frame. This rule is what `missed_captures` measures.
- ID arithmetic is unsigned modulo 2^`PARTICLE_ID_WIDTH`. Comparisons against count use `PARTICLE_ID_WIDTH+1` bits, so count = 2^W−1 works without wrap.

## Timing
- Reset (async assert, sync release): state IDLE, FIFO empty, `ref_valid`=0, `ref_id`/`ref_x`/`ref_y`/`ref_z`=0, `ref_particle_num`=0, `frame_done`=0, `missed_captures`=0.
- Capture latency: a beat captured at edge N into an empty FIFO gives `ref_valid`=1 with that data after edge N.
- Pop: new head visible after the popping edge. If empty, `ref_valid` falls after that edge.
- Simultaneous push and pop on a single-entry FIFO: the pushed entry becomes the head after the edge; `ref_valid` stays 1.
- Header: at the edge after the header beat, `ref_valid`=0 and `frame_done`=0 (or 1 if count = 0).
- Reset mid-frame: everything returns to reset values immediately; no partial state survives.
- Throughput: one capture and one pop per cycle.

## Configuration
- `REF_PREFETCH_STATS_EN` defined:
  - `missed_captures` increments, saturating at 16'hFFFF, on every RUN-state data beat with `in_id == cap_id` and `cap_id < ref_particle_num` that is dropped because the FIFO is full.
  - The counter clears on a header beat and on reset.
- Not defined: `missed_captures` is tied to 0 and its logic is removed.

## Test plan
- Header count=3, then beats ID 0,1,2 with x offsets 5,6,7 and `ref_advance` low → after the ID 0 edge `ref_valid`=1, `ref_id`=0, `ref_x`=`{3'b010,29'd5}`; FIFO holds 3 entries. Then 3 pops on consecutive cycles → `ref_id` 1, 2, then `ref_valid`=0 and `frame_done`=1.
- `PREFETCH_DEPTH`=4, count=8, stream IDs 0–7 with no pops → only IDs 0–3 captured. With STATS_EN, the ID 4 beat gives `missed_captures`=1. Re-broadcast IDs 4–7 after 2 pops → IDs 4, 5 captured.
- Out-of-order beats 1,0,1 after header count=2 → ID 1 ignored, ID 0 captured, then ID 1 captured; `ref_id` sequence 0, 1.
- Header count=0 → `frame_done`=1 next cycle, `ref_valid`=0. Subsequent data beats ignored.
- Full FIFO with `ref_advance` and matching beat in the same cycle → pop and push both occur; occupancy unchanged.
- Header mid-frame, and `rst` asserted mid-frame between edges → FIFO flushes, `ref_valid`=0 (immediately for `rst`). After `rst`, all outputs are 0 and state is IDLE.
